nonce_sweep_controller: RTL and testbench

- Sequences one mining job across the hashing cores, then hands the job's outcome to the host interface.
- On a new block it runs the header broadcast phase, then sweeps the shared nonce suffix through every value.
- It tags returning per-core success flags with the suffix they belong to, arbitrates simultaneous winners, and reports one result per job.
- It sits between the host/block-load logic and the core array, alongside the nonce decoder.

---
 rtl/nonce_sweep_controller_pkg.sv | 25 ++
 rtl/nonce_tag_pipe.sv | 43 ++++
 rtl/nonce_sweep_controller.sv | 156 +++++++++++++++
 tb/tb_nonce_sweep_controller.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/nonce_sweep_controller_pkg.sv
// Shared mining definitions: sweep FSM state codes, suffix-width helper and the
// per-job result record passed on to the nonce decoder and host interface.
package nonce_sweep_controller_pkg;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE   = 3'd0;
    localparam state_t ST_BCAST  = 3'd1;
    localparam state_t ST_SWEEP  = 3'd2;
    localparam state_t ST_DRAIN  = 3'd3;
    localparam state_t ST_REPORT = 3'd4;

    localparam int RESULT_NONCE_BITS = 32;

    typedef struct packed {
        logic                         success;
        logic [RESULT_NONCE_BITS-1:0] nonce;
    } result_t;

    // Suffix is whatever remains of the nonce once the core prefix is taken off.
    function automatic int suffix_width(input int nonce_bits, input int part_bits);
        return nonce_bits - part_bits;
    endfunction

endpackage

// File: rtl/nonce_tag_pipe.sv
// Delay line that carries each issued suffix and its valid bit forward until the
// matching core_success flags come back; clr_i invalidates everything in flight.
module nonce_tag_pipe #(
    parameter int DEPTH = 3,
    parameter int W     = 30
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr_i,
    input  logic         vld_i,
    input  logic [W-1:0] base_i,
    output logic         vld_o,
    output logic [W-1:0] base_o
);

    logic [DEPTH-1:0]        vld_q, vld_d;
    logic [DEPTH-1:0][W-1:0] base_q, base_d;

    always_comb begin
        vld_d     = '0;
        base_d    = '0;
        vld_d[0]  = vld_i & ~clr_i;
        base_d[0] = base_i;
        for (int i = 1; i < DEPTH; i++) begin
            vld_d[i]  = vld_q[i-1] & ~clr_i;
            base_d[i] = base_q[i-1];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_q  <= '0;
            base_q <= '0;
        end else begin
            vld_q  <= vld_d;
            base_q <= base_d;
        end
    end

    assign vld_o  = vld_q[DEPTH-1];
    assign base_o = base_q[DEPTH-1];

endmodule

// File: rtl/nonce_sweep_controller.sv
// Runs one mining job: header broadcast, full suffix sweep, pipeline drain, and a
// single result report with lowest-core-index arbitration between winners.
module nonce_sweep_controller
    import nonce_sweep_controller_pkg::*;
#(
    parameter int NUM_CORES     = 4,
    parameter int PARTITIONBITS = 2,
    parameter int BROADCAST_CNT = 5,
    parameter int PIPE_LATENCY  = 3,
    parameter int NONCE_BITS    = 32,
    localparam int SW = suffix_width(NONCE_BITS, PARTITIONBITS),
    localparam int BW = (BROADCAST_CNT > 1) ? $clog2(BROADCAST_CNT) : 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start_i,
    input  logic                  abort_i,
    output logic                  busy_o,
    output logic                  broadcast_o,
    output logic [BW-1:0]         bcast_idx_o,
    output logic                  nonce_valid_o,
    output logic [SW-1:0]         nonce_base_o,
    input  logic [NUM_CORES-1:0]  core_success_i,
    output logic                  result_valid_o,
    output logic                  success_o,
    output logic [NONCE_BITS-1:0] nonce_o
);

    localparam int DW = (PIPE_LATENCY > 1) ? $clog2(PIPE_LATENCY) : 1;
    localparam logic [BW-1:0] BCAST_LAST = BW'(BROADCAST_CNT - 1);
    localparam logic [DW-1:0] DRAIN_LAST = DW'(PIPE_LATENCY - 1);
    localparam logic [SW-1:0] BASE_LAST  = {SW{1'b1}};

    state_t                  state_q, state_d;
    logic [BW-1:0]           bcast_cnt_q, bcast_cnt_d;
    logic [SW-1:0]           base_q, base_d;
    logic [DW-1:0]           drain_cnt_q, drain_cnt_d;
    logic                    success_q, success_d;
    logic [NONCE_BITS-1:0]   nonce_q, nonce_d;

    logic                     tag_clr;
    logic                     tag_vld;
    logic [SW-1:0]            tag_base;
    logic [PARTITIONBITS-1:0] winner;
    logic                     hit;

    nonce_tag_pipe #(
        .DEPTH (PIPE_LATENCY),
        .W     (SW)
    ) u_tag_pipe (
        .clk    (clk),
        .rst    (rst),
        .clr_i  (tag_clr),
        .vld_i  (nonce_valid_o),
        .base_i (nonce_base_o),
        .vld_o  (tag_vld),
        .base_o (tag_base)
    );

    // Scan downward so the lowest set core index is the one left standing.
    always_comb begin
        winner = '0;
        for (int k = NUM_CORES - 1; k >= 0; k--) begin
            if (core_success_i[k]) winner = PARTITIONBITS'(k);
        end
    end

    assign hit = tag_vld && (|core_success_i) &&
                 ((state_q == ST_SWEEP) || (state_q == ST_DRAIN));

    always_comb begin
        state_d     = state_q;
        bcast_cnt_d = bcast_cnt_q;
        base_d      = base_q;
        drain_cnt_d = drain_cnt_q;
        success_d   = success_q;
        nonce_d     = nonce_q;
        tag_clr     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    state_d     = ST_BCAST;
                    bcast_cnt_d = '0;
                    success_d   = 1'b0;
                    nonce_d     = '0;
                    tag_clr     = 1'b1;
                end
            end
            ST_BCAST: begin
                if (bcast_cnt_q == BCAST_LAST) begin
                    state_d = ST_SWEEP;
                    base_d  = '0;
                end else begin
                    bcast_cnt_d = bcast_cnt_q + 1'b1;
                end
            end
            ST_SWEEP: begin
                if (base_q == BASE_LAST) begin
                    state_d     = ST_DRAIN;
                    drain_cnt_d = '0;
                end else begin
                    base_d = base_q + 1'b1;
                end
            end
            ST_DRAIN: begin
                if (drain_cnt_q == DRAIN_LAST) state_d = ST_REPORT;
                else                           drain_cnt_d = drain_cnt_q + 1'b1;
            end
            ST_REPORT: state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase

        // A late hit beats the end of the sweep or drain; abort beats everything.
        if (hit) begin
            state_d   = ST_REPORT;
            success_d = 1'b1;
            nonce_d   = {winner, tag_base};
        end

        if (abort_i && (state_q != ST_IDLE)) begin
            state_d   = ST_IDLE;
            success_d = success_q;
            nonce_d   = nonce_q;
            tag_clr   = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            bcast_cnt_q <= '0;
            base_q      <= '0;
            drain_cnt_q <= '0;
            success_q   <= 1'b0;
            nonce_q     <= '0;
        end else begin
            state_q     <= state_d;
            bcast_cnt_q <= bcast_cnt_d;
            base_q      <= base_d;
            drain_cnt_q <= drain_cnt_d;
            success_q   <= success_d;
            nonce_q     <= nonce_d;
        end
    end

    assign busy_o         = (state_q != ST_IDLE);
    assign broadcast_o    = (state_q == ST_BCAST);
    assign bcast_idx_o    = broadcast_o ? bcast_cnt_q : '0;
    assign nonce_valid_o  = (state_q == ST_SWEEP);
    assign nonce_base_o   = nonce_valid_o ? base_q : '0;
    assign result_valid_o = (state_q == ST_REPORT);
    assign success_o      = success_q;
    assign nonce_o        = nonce_q;

endmodule

// File: tb/tb_nonce_sweep_controller.sv
// Bench for nonce_sweep_controller with an 8-bit nonce: each job is predicted from
// its hit schedule with cycle arithmetic and every output is compared each cycle.
module tb_nonce_sweep_controller;

    localparam int NC        = 4;
    localparam int PB        = 2;
    localparam int B         = 5;
    localparam int L         = 3;
    localparam int NBITS     = 8;
    localparam int SWID      = 6;
    localparam int NSUF      = 64;
    localparam int FIRST_TAG = B + L + 1;
    localparam int LAST_TAG  = B + NSUF + L;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             start_i = 1'b0;
    logic             abort_i = 1'b0;
    logic             busy_o;
    logic             broadcast_o;
    logic [2:0]       bcast_idx_o;
    logic             nonce_valid_o;
    logic [SWID-1:0]  nonce_base_o;
    logic [NC-1:0]    core_success_i = '0;
    logic             result_valid_o;
    logic             success_o;
    logic [NBITS-1:0] nonce_o;

    int n_checks = 0;
    int n_fail   = 0;
    logic [3:0] hit_mask [0:127];

    nonce_sweep_controller #(
        .NUM_CORES     (NC),
        .PARTITIONBITS (PB),
        .BROADCAST_CNT (B),
        .PIPE_LATENCY  (L),
        .NONCE_BITS    (NBITS)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .start_i        (start_i),
        .abort_i        (abort_i),
        .busy_o         (busy_o),
        .broadcast_o    (broadcast_o),
        .bcast_idx_o    (bcast_idx_o),
        .nonce_valid_o  (nonce_valid_o),
        .nonce_base_o   (nonce_base_o),
        .core_success_i (core_success_i),
        .result_valid_o (result_valid_o),
        .success_o      (success_o),
        .nonce_o        (nonce_o)
    );

    always #5 clk = ~clk;

    function automatic logic [21:0] snap();
        return {busy_o, broadcast_o, bcast_idx_o, nonce_valid_o, nonce_base_o,
                result_valid_o, success_o, nonce_o};
    endfunction

    task automatic clear_hits();
        for (int i = 0; i < 128; i++) hit_mask[i] = '0;
    endtask

    // Cycle 0 carries start_i; cycle t is the clock period after the t-th edge.
    task automatic run_job(input string name, input int abort_req, input int busy_start);
        int found, e, aborted, last, stop;
        logic [3:0] m;
        logic [7:0] res;
        logic bsy, bc, nv, rv, sc;
        logic [2:0] idx;
        logic [5:0] base;
        logic [21:0] exp_v, got_v;
        found = 0;
        e = LAST_TAG;
        for (int c = FIRST_TAG; c <= LAST_TAG; c++) begin
            if (found == 0 && hit_mask[c] != 4'd0) begin
                found = 1;
                e = c;
            end
        end
        res = 8'h00;
        if (found != 0) begin
            m = hit_mask[e];
            for (int k = 3; k >= 0; k--) if (m[k]) res[7:6] = 2'(k);
            res[5:0] = 6'(e - FIRST_TAG);
        end
        aborted = (abort_req > 0 && abort_req <= e) ? 1 : 0;
        last = (aborted != 0) ? abort_req : e + 1;
        stop = (aborted != 0) ? abort_req : e;

        @(negedge clk);
        start_i = 1'b1;
        core_success_i = '0;
        abort_i = 1'b0;
        for (int t = 1; t <= last + 2; t++) begin
            @(negedge clk);
            start_i = (t == busy_start && t <= last);
            bsy  = (t <= last);
            bc   = (t <= B && t <= stop);
            idx  = bc ? 3'(t - 1) : 3'd0;
            nv   = (t >= B + 1 && t <= B + NSUF && t <= stop);
            base = nv ? 6'(t - B - 1) : 6'd0;
            rv   = (aborted == 0 && t == e + 1);
            sc   = (aborted == 0 && found != 0 && t >= e + 1);
            exp_v = {bsy, bc, idx, nv, base, rv, sc, (sc ? res : 8'h00)};
            got_v = snap();
            n_checks++;
            if (got_v !== exp_v) begin
                n_fail++;
                $display("FAIL %s cycle %0d: outputs %h, expected %h", name, t, got_v, exp_v);
            end
            core_success_i = hit_mask[t];
            abort_i = (aborted != 0 && t == abort_req);
        end
        start_i = 1'b0;
        core_success_i = '0;
        abort_i = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        n_checks++;
        if (snap() !== 22'd0) begin
            n_fail++;
            $display("FAIL reset_initial: outputs %h, expected 0", snap());
        end
        rst = 1'b0;
        @(negedge clk);
        start_i = 1'b1;
        for (int t = 1; t <= B + 1 + 20; t++) begin
            @(negedge clk);
            start_i = 1'b0;
        end
        n_checks++;
        if (!(nonce_valid_o === 1'b1 && nonce_base_o === 6'd20)) begin
            n_fail++;
            $display("FAIL reset_pre_base: valid %b base %0d, expected 1 / 20",
                     nonce_valid_o, nonce_base_o);
        end
        #1 rst = 1'b1;
        #1;
        n_checks++;
        if (snap() !== 22'd0) begin
            n_fail++;
            $display("FAIL reset_async: outputs %h, expected 0", snap());
        end
        @(negedge clk);
        n_checks++;
        if (snap() !== 22'd0) begin
            n_fail++;
            $display("FAIL reset_held: outputs %h, expected 0", snap());
        end
        rst = 1'b0;
        clear_hits();
        hit_mask[FIRST_TAG + 5] = 4'b0001;
        run_job("reset_restart", 0, 0);
    endtask

    task automatic test_broadcast();
        clear_hits();
        for (int t = 1; t <= B; t++) hit_mask[t] = 4'b1111;
        for (int t = B + 1; t < FIRST_TAG; t++) hit_mask[t] = 4'b1111;
        hit_mask[FIRST_TAG + 12] = 4'b0010;
        run_job("broadcast", 0, 0);
    endtask

    task automatic test_single_hit();
        clear_hits();
        hit_mask[FIRST_TAG + 9] = 4'b0100;
        run_job("hit_base9", 0, 0);
        n_checks++;
        if (nonce_o !== 8'h89 || success_o !== 1'b1) begin
            n_fail++;
            $display("FAIL hit_base9_hold: success %b nonce %h, expected 1 / 89", success_o, nonce_o);
        end
    endtask

    task automatic test_priority();
        clear_hits();
        hit_mask[FIRST_TAG + 3] = 4'b1010;
        hit_mask[FIRST_TAG + 4] = 4'b1000;
        run_job("priority", 0, 0);
        n_checks++;
        if (nonce_o !== 8'h43) begin
            n_fail++;
            $display("FAIL priority_nonce: nonce %h, expected 43", nonce_o);
        end
    endtask

    task automatic test_no_hit();
        clear_hits();
        run_job("no_hit", 0, 0);
        n_checks++;
        if (success_o !== 1'b0 || nonce_o !== 8'h00) begin
            n_fail++;
            $display("FAIL no_hit_result: success %b nonce %h, expected 0 / 00", success_o, nonce_o);
        end
        clear_hits();
        hit_mask[LAST_TAG] = 4'b0100;
        run_job("last_drain_hit", 0, 0);
        n_checks++;
        if (success_o !== 1'b1 || nonce_o !== 8'hBF) begin
            n_fail++;
            $display("FAIL last_drain_result: success %b nonce %h, expected 1 / bf", success_o, nonce_o);
        end
    endtask

    task automatic test_abort();
        clear_hits();
        hit_mask[B + 1 + 30] = 4'b0001;
        run_job("abort_base30", B + 1 + 30, 0);
        clear_hits();
        hit_mask[FIRST_TAG + 40] = 4'b1000;
        run_job("start_while_busy", 0, B + 1 + 14);
    endtask

    task automatic test_random();
        int n, c, ab;
        for (int j = 0; j < 8; j++) begin
            clear_hits();
            n = $urandom_range(0, 3);
            for (int i = 0; i < n; i++) begin
                c = $urandom_range(1, LAST_TAG);
                hit_mask[c] = 4'($urandom_range(1, 15));
            end
            ab = ($urandom_range(0, 3) == 0) ? $urandom_range(1, LAST_TAG) : 0;
            run_job("random", ab, ($urandom_range(0, 1) != 0) ? $urandom_range(1, 20) : 0);
        end
    endtask

    initial begin
        clear_hits();
        test_reset();
        test_broadcast();
        test_single_hit();
        test_priority();
        test_no_hit();
        test_abort();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
